// File: rtl/reg_read_stage.sv
// Operand-fetch stage: scoreboard-based RAW/WAW hazard stall, writeback bypass,
// and a registered operand slot for execute.
module reg_read_stage #(
    parameter int OPW = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           dec_valid,
    output logic           dec_ready,
    input  logic [OPW-1:0] dec_op,
    input  logic [3:0]     dec_src_a,
    input  logic [3:0]     dec_src_b,
    input  logic           dec_use_a,
    input  logic           dec_use_b,
    input  logic [3:0]     dec_dst,
    input  logic           dec_dst_en,
    output logic [3:0]     rf_addr_a,
    output logic [3:0]     rf_addr_b,
    input  logic [63:0]    rf_data_a,
    input  logic [63:0]    rf_data_b,
    input  logic           wb_valid,
    input  logic [3:0]     wb_reg,
    input  logic [63:0]    wb_data,
    input  logic           flush,
    output logic           ex_valid,
    input  logic           ex_ready,
    output logic [OPW-1:0] ex_op,
    output logic [63:0]    ex_opnd_a,
    output logic [63:0]    ex_opnd_b,
    output logic [3:0]     ex_dst,
    output logic           ex_dst_en,
    output logic [31:0]    stall_cycles
);

    logic [15:0]    r_busy;
    logic           r_ex_valid;
    logic [OPW-1:0] r_ex_op;
    logic [63:0]    r_ex_opnd_a;
    logic [63:0]    r_ex_opnd_b;
    logic [3:0]     r_ex_dst;
    logic           r_ex_dst_en;
    logic [31:0]    r_stall;

    logic [15:0]    w_wb_mask;
    logic [15:0]    w_set_mask;
    logic [15:0]    w_eff_busy;
    logic           w_hazard;
    logic           w_out_free;
    logic           w_accept;
    logic [63:0]    w_opnd_a;
    logic [63:0]    w_opnd_b;

    assign rf_addr_a = dec_src_a;
    assign rf_addr_b = dec_src_b;

    // A register being written back this cycle is no longer a hazard: its value is bypassed.
    assign w_wb_mask  = wb_valid ? (16'h0001 << wb_reg) : 16'h0000;
    assign w_eff_busy = r_busy & ~w_wb_mask;

    assign w_hazard = (dec_use_a  & w_eff_busy[dec_src_a]) |
                      (dec_use_b  & w_eff_busy[dec_src_b]) |
                      (dec_dst_en & w_eff_busy[dec_dst]);

    assign w_out_free = ~r_ex_valid | ex_ready;
    assign dec_ready  = w_out_free & ~w_hazard & ~flush;
    assign w_accept   = dec_valid & dec_ready;
    assign w_set_mask = (w_accept & dec_dst_en) ? (16'h0001 << dec_dst) : 16'h0000;

    assign w_opnd_a = !dec_use_a ? 64'h0 :
                      (wb_valid && wb_reg == dec_src_a) ? wb_data : rf_data_a;
    assign w_opnd_b = !dec_use_b ? 64'h0 :
                      (wb_valid && wb_reg == dec_src_b) ? wb_data : rf_data_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_op     <= '0;
            r_ex_opnd_a <= '0;
            r_ex_opnd_b <= '0;
            r_ex_dst    <= '0;
            r_ex_dst_en <= 1'b0;
            r_stall     <= '0;
        end else begin
            if (dec_valid && w_hazard && w_out_free && !flush)
                r_stall <= r_stall + 32'd1;

            if (flush) begin
                r_ex_valid <= 1'b0;
                r_busy     <= '0;
            end else begin
                // Set after clear so a same-cycle issue of a just-retired register stays busy.
                r_busy <= (r_busy & ~w_wb_mask) | w_set_mask;
                if (w_accept) begin
                    r_ex_valid  <= 1'b1;
                    r_ex_op     <= dec_op;
                    r_ex_opnd_a <= w_opnd_a;
                    r_ex_opnd_b <= w_opnd_b;
                    r_ex_dst    <= dec_dst;
                    r_ex_dst_en <= dec_dst_en;
                end else if (ex_ready) begin
                    r_ex_valid <= 1'b0;
                end
            end
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_op        = r_ex_op;
    assign ex_opnd_a    = r_ex_opnd_a;
    assign ex_opnd_b    = r_ex_opnd_b;
    assign ex_dst       = r_ex_dst;
    assign ex_dst_en    = r_ex_dst_en;
    assign stall_cycles = r_stall;

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Operand-fetch stage between instruction decode and execute. It reads source operands from the 16-entry 64-bit register file, tracks in-flight destination registers in a scoreboard, and stalls decode on RAW/WAW hazards. It forwards same-cycle writeback data, registers the operands for execute, and counts hazard stall cycles.

## Interface
Parameters:
- OPW, 32, width of the opaque decoded-op bundle passed through to execute

Ports (clk and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  stage accepts the instruction this cycle
- dec_op  in  OPW  decoded-op bundle
- dec_src_a / dec_src_b  in  4 each  source register indices
- dec_use_a / dec_use_b  in  1 each  source is actually read
- dec_dst  in  4  destination register index
- dec_dst_en  in  1  instruction writes dec_dst
- rf_addr_a / rf_addr_b  out  4 each  register file read addresses (= dec_src_a/b, combinational)
- rf_data_a / rf_data_b  in  64 each  register file read data (combinational, pre-write value)
- wb_valid  in  1  writeback this cycle (register file written at this edge)
- wb_reg  in  4  writeback register index
- wb_data  in  64  writeback value
- flush  in  1  discard staged instruction and clear scoreboard
- ex_valid  out  1  operands valid for execute
- ex_ready  in  1  execute consumes this cycle
- ex_op  out  OPW  registered dec_op
- ex_opnd_a / ex_opnd_b  out  64 each  registered operands
- ex_dst / ex_dst_en  out  4 / 1  registered destination
- stall_cycles  out  32  hazard stall counter

## Operation
- Scoreboard: 16 busy bits, busy[r]=1 while a producer of r is accepted but not written back.
- eff_busy[r] = busy[r] & ~(wb_valid & wb_reg==r).
- hazard = (dec_use_a & eff_busy[src_a]) | (dec_use_b & eff_busy[src_b]) | (dec_dst_en & eff_busy[dst]).
- out_free = ~ex_valid | ex_ready.
- dec_ready = out_free & ~hazard & ~flush (combinational on dec_* inputs; decode must not depend on dec_ready to drive dec_valid).
- accept = dec_valid & dec_ready.
- Operand select per source: wb_valid & wb_reg==src -> wb_data, else rf_data. Unused sources (use=0) load 64'h0.
- On accept: ex_* <- selected operands/op/dst, ex_valid <- 1; if dec_dst_en, busy[dst] <- 1.
- Else if ex_ready: ex_valid <- 0; other ex_* hold.
- Writeback: wb_valid clears busy[wb_reg]. Set and clear of same register in one cycle -> set wins.
- wb_valid for a non-busy register: ignored by the scoreboard, bypass still applies.
- WAW stall guarantees at most one outstanding producer per register.
- flush: ex_valid <- 0, all busy <- 0, no accept that cycle; flush has priority over accept and writeback.
- stall_cycles: +1 each cycle with dec_valid & hazard & out_free & ~flush; wraps at 2^32-1 -> 0; not cleared by flush.
- Indices are 4-bit; RAX=0, RCX=1, RDX=2, RBX=3, RSP=4, RBP=5, RSI=6, RDI=7, R8-R15=8-15.

## Timing
- Reset values: ex_valid 0, ex_op 0, ex_opnd_a/b 0, ex_dst 0, ex_dst_en 0, busy all 0, stall_cycles 0. dec_ready is combinational: after reset it follows ~hazard & ~flush.
- Latency: accept in cycle N -> ex_valid in cycle N+1.
- Throughput: one instruction per cycle with no hazards and ex_ready held high.
- While ex_valid & ~ex_ready, all ex_* outputs hold stable.
- Dependent instruction issues in the same cycle as the producer's wb_valid, using the bypassed wb_data.
- reset mid-operation clears everything on the next edge, regardless of flush, wb, or accept.

## Test plan
- Reset, then dec src_a=0/src_b=3 use both, dst=1, rf_data_a=5, rf_data_b=7, ex_ready=1 -> next cycle ex_valid=1, ex_opnd_a=5, ex_opnd_b=7, busy[1]=1.
- Issue dst=2, then src_a=2 -> dec_ready=0 and stall_cycles increments each cycle; wb_valid, wb_reg=2, wb_data=64'hDEAD that cycle -> accepted, ex_opnd_a=64'hDEAD next cycle.
- Back-to-back dst=9 twice with no wb -> second instruction stalls (WAW) until wb_reg=9.
- ex_ready=0 with ex_valid=1 -> ex_* stable, dec_ready=0, stall_cycles unchanged; ex_ready=1 -> the pending decode instruction is accepted in that same cycle.
- Same cycle: accept dst=4 and wb_reg=4 -> busy[4]=1 afterwards.
- busy[5]=1, ex_valid=1, assert flush with dec_valid=1 -> next cycle ex_valid=0, busy all 0, stall_cycles unchanged; src=5 is then accepted without stalling.
